am_fifo: RTL and testbench

Input-buffered 24x24 mantissa multiplier for the Goldschmidt divider datapath. Every clock it captures an operand pair (low 24 bits of `a_in` and `b_in`) into a small synchronous FIFO. When the consumer asserts `rd_en`, it pops the oldest pair and registers the 48-bit unsigned product. It decouples operand producers from the multiplier stage.

---
 rtl/am_fifo.sv | 97 +++++++++
 tb/tb_am_fifo.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/am_fifo.sv
// am_fifo: operand-pair FIFO feeding a 24x24 unsigned mantissa multiplier.
// Every non-reset edge offers {a[23:0], b[23:0]} to the queue. Each accepted
// pop multiplies the oldest pair into a registered 48-bit product.
module am_fifo #(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        clear_b,
    input  logic [31:0] a_in,
    input  logic [31:0] b_in,
    input  logic        rd_en,
    output logic [47:0] product
);

    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ZERO = {(AW+1){1'b0}};
    localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] PTR_ZERO = {AW{1'b0}};
    localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};

    // Queue storage and bookkeeping
    logic [47:0]   mem_r [0:DEPTH-1];
    logic [AW-1:0] wp_r;
    logic [AW-1:0] rp_r;
    logic [AW:0]   cnt_r;
    logic [47:0]   product_r;

    // Combinational helpers
    logic          empty_s;
    logic          full_s;
    logic          rd_ok_s;
    logic          wr_ok_s;
    logic [47:0]   head_s;
    logic [47:0]   prod_s;
    logic [47:0]   wdata_s;
    logic [AW:0]   cnt_nxt_s;
    logic          unused_s;

    // The upper operand bytes carry no mantissa information.
    assign unused_s = ^{a_in[31:24], b_in[31:24]};

    assign product = product_r;

    // Decide which transfers happen this edge, judged on pre-edge occupancy.
    always_comb begin
        empty_s = (cnt_r == CNT_ZERO);
        full_s  = (cnt_r == CNT_FULL);
        rd_ok_s = rd_en & ~empty_s;
        // When full, a same-edge pop frees the slot for the incoming pair.
        wr_ok_s = ~full_s | rd_ok_s;
        wdata_s = {a_in[23:0], b_in[23:0]};
    end

    // Multiply the head pair; only consumed when a pop is accepted.
    always_comb begin
        head_s = mem_r[rp_r];
        prod_s = {24'h000000, head_s[47:24]} * {24'h000000, head_s[23:0]};
    end

    // Next occupancy: push-only grows, pop-only shrinks, both or neither hold.
    always_comb begin
        cnt_nxt_s = cnt_r;
        case ({wr_ok_s, rd_ok_s})
            2'b10:   cnt_nxt_s = cnt_r + CNT_ONE;
            2'b01:   cnt_nxt_s = cnt_r - CNT_ONE;
            default: cnt_nxt_s = cnt_r;
        endcase
    end

    // Storage array: written on accepted pushes, never cleared.
    always_ff @(posedge clk) begin
        if (!clear_b && wr_ok_s) begin
            mem_r[wp_r] <= wdata_s;
        end
    end

    // Pointers, occupancy and the product register, with synchronous clear.
    always_ff @(posedge clk) begin
        if (clear_b) begin
            wp_r      <= PTR_ZERO;
            rp_r      <= PTR_ZERO;
            cnt_r     <= CNT_ZERO;
            product_r <= 48'h0;
        end else begin
            cnt_r <= cnt_nxt_s;
            if (wr_ok_s) begin
                wp_r <= wp_r + PTR_ONE;
            end
            if (rd_ok_s) begin
                rp_r      <= rp_r + PTR_ONE;
                product_r <= prod_s;
            end
        end
    end

endmodule

// File: tb/tb_am_fifo.sv
// Self-checking bench for am_fifo: directed scenarios plus random traffic,
// all compared against a queue-based reference model.
module tb_am_fifo;

    localparam int DEPTH = 8;

    logic        clk;
    logic        clear_b;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        rd_en;
    logic [47:0] product;

    int n_vec;
    int n_err;

    // Reference model state
    logic [47:0] model_q[$];
    logic [47:0] exp_product;

    am_fifo #(.DEPTH(DEPTH)) dut (
        .clk     (clk),
        .clear_b (clear_b),
        .a_in    (a_in),
        .b_in    (b_in),
        .rd_en   (rd_en),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [47:0] got, input logic [47:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: drive inputs, let the edge happen, advance model, compare.
    task automatic step(input logic [31:0] a, input logic [31:0] b,
                        input logic rd, input logic clr, input string tag);
        logic [47:0] head;
        logic        rd_ok;
        logic        wr_ok;
        a_in    = a;
        b_in    = b;
        rd_en   = rd;
        clear_b = clr;
        @(posedge clk);
        if (clr) begin
            model_q.delete();
            exp_product = 48'h0;
        end else begin
            rd_ok = rd && (model_q.size() > 0);
            wr_ok = (model_q.size() < DEPTH) || rd_ok;
            if (rd_ok) begin
                head = model_q.pop_front();
                exp_product = 48'(head[47:24]) * 48'(head[23:0]);
            end
            if (wr_ok) model_q.push_back({a[23:0], b[23:0]});
        end
        #1;
        check_val(tag, product, exp_product);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        exp_product = 48'h0;
        a_in = 32'h0; b_in = 32'h0; rd_en = 1'b0; clear_b = 1'b1;

        // Reset held for two edges with reads requested
        step(32'h12345678, 32'h9ABCDEF0, 1'b1, 1'b1, "reset0");
        step(32'h00FFFFFF, 32'h00FFFFFF, 1'b1, 1'b1, "reset1");
        check_val("reset_zero", product, 48'h0);
        step(32'h0, 32'h0, 1'b1, 1'b0, "read_empty");
        check_val("read_empty_zero", product, 48'h0);

        // Basic ordering
        step(32'h0, 32'h0, 1'b0, 1'b1, "clr_basic");
        step(32'h00111111, 32'h00000001, 1'b0, 1'b0, "basic_w0");
        step(32'h00111111, 32'h00000011, 1'b1, 1'b0, "basic_r0");
        check_val("basic_p0", product, 48'h000000111111);
        step(32'h00111111, 32'h00000111, 1'b1, 1'b0, "basic_r1");
        check_val("basic_p1", product, 48'h000001222221);
        step(32'h00ABCCD1, 32'h002314A5, 1'b1, 1'b0, "basic_r2");
        check_val("basic_p2", product, 48'h000012333321);
        step(32'h0, 32'h0, 1'b1, 1'b0, "basic_r3");
        check_val("basic_p3", product, 48'h00ABCCD1 * 48'h002314A5);

        // Upper-bit masking
        step(32'h0, 32'h0, 1'b0, 1'b1, "clr_mask");
        step(32'hFF111111, 32'hAB000011, 1'b0, 1'b0, "mask_w0");
        step(32'h00FFFFFF, 32'h00FFFFFF, 1'b1, 1'b0, "mask_r0");
        check_val("mask_p0", product, 48'h000001222221);
        step(32'h0, 32'h0, 1'b1, 1'b0, "mask_r1");
        check_val("mask_p1", product, 48'hFFFFFE000001);

        // Full / drop behaviour
        step(32'h0, 32'h0, 1'b0, 1'b1, "clr_full");
        for (int k = 0; k < DEPTH + 3; k++) begin
            step(32'(k + 1), 32'h1, 1'b0, 1'b0, "full_fill");
            check_val("full_hold", product, 48'h0);
        end
        for (int k = 0; k < DEPTH + 3; k++) begin
            step(32'h0, 32'h0, 1'b1, 1'b0, "full_drain");
            check_val("full_order", product, (k < DEPTH) ? 48'(k + 1) : 48'h0);
        end

        // Wrap-around streaming
        step(32'h0, 32'h0, 1'b0, 1'b1, "clr_wrap");
        step($urandom, $urandom, 1'b0, 1'b0, "wrap_prime");
        for (int k = 0; k < 3 * DEPTH; k++) begin
            step($urandom, $urandom, 1'b1, 1'b0, "wrap_stream");
        end

        // Mid-operation reset
        step(32'h0, 32'h0, 1'b0, 1'b1, "clr_mid");
        for (int k = 0; k < 5; k++) begin
            step(32'(k + 7), 32'(k + 9), 1'b0, 1'b0, "mid_fill");
        end
        step(32'h00000042, 32'h00000042, 1'b1, 1'b1, "mid_pulse");
        step(32'h00000003, 32'h00000005, 1'b1, 1'b0, "mid_empty");
        check_val("mid_zero", product, 48'h0);
        step(32'h0, 32'h0, 1'b1, 1'b0, "mid_post");
        check_val("mid_post_val", product, 48'd15);

        // Random traffic with occasional resets
        for (int k = 0; k < 400; k++) begin
            step($urandom, $urandom, 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 39) == 0), "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
